// File: rtl/ddsm_word_scheduler.sv
// ============================================================================
// Module   : ddsm_word_scheduler
// Brief    : Buffers one fractional word and applies its four segments
//            coherently, then holds off further updates until the skewed
//            DDSM input pipeline has settled.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ddsm_word_scheduler #(
    parameter int P_INPUT_WIDTH   = 6,
    parameter int P_SETTLE_CYCLES = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [4*P_INPUT_WIDTH-1:0] i_word,
    input  logic                       i_word_valid,
    output logic                       o_word_ready,
    input  logic                       i_freeze,
    output logic [P_INPUT_WIDTH-1:0]   o_msb,
    output logic [P_INPUT_WIDTH-1:0]   o_isb1,
    output logic [P_INPUT_WIDTH-1:0]   o_isb2,
    output logic [P_INPUT_WIDTH-1:0]   o_lsb,
    output logic                       o_update,
    output logic                       o_settled,
    output logic                       o_busy
);

    localparam int c_W          = P_INPUT_WIDTH;
    localparam int c_SETTLE_LEN = 4 + P_SETTLE_CYCLES;
    localparam int c_CNT_W      = $clog2(c_SETTLE_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(c_SETTLE_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_pend_vld;
    logic [4*c_W-1:0]     r_pend_word;
    logic [c_W-1:0]       r_msb;
    logic [c_W-1:0]       r_isb1;
    logic [c_W-1:0]       r_isb2;
    logic [c_W-1:0]       r_lsb;
    logic                 r_update;
    logic                 r_settled;
    logic                 r_busy;

    logic                 w_accept;
    logic                 w_apply;
    logic                 w_finish;
    logic                 w_busy_nxt;

    assign o_word_ready = ~r_pend_vld & ~i_rst;
    assign w_accept     = i_word_valid & o_word_ready;
    assign w_apply      = (r_state == ST_IDLE) & r_pend_vld & ~i_freeze;
    assign w_finish     = (r_state == ST_SETTLE) & ~i_freeze & (r_cnt == '0);

    // Busy mirrors the post-edge state: settling, or a word still waiting.
    assign w_busy_nxt = w_apply
                      | ((r_state == ST_SETTLE) & ~w_finish)
                      | (r_pend_vld & ~w_apply)
                      | w_accept;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_word <= '0;
            r_msb       <= '0;
            r_isb1      <= '0;
            r_isb2      <= '0;
            r_lsb       <= '0;
            r_update    <= 1'b0;
            r_settled   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_update  <= 1'b0;
            r_settled <= 1'b0;
            r_busy    <= w_busy_nxt;

            if (w_accept) begin
                r_pend_word <= i_word;
                r_pend_vld  <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_apply) begin
                        r_msb      <= r_pend_word[4*c_W-1:3*c_W];
                        r_isb1     <= r_pend_word[3*c_W-1:2*c_W];
                        r_isb2     <= r_pend_word[2*c_W-1:c_W];
                        r_lsb      <= r_pend_word[c_W-1:0];
                        r_pend_vld <= 1'b0;
                        r_update   <= 1'b1;
                        r_cnt      <= c_CNT_LOAD;
                        r_state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!i_freeze) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - c_CNT_W'(1);
                        end else begin
                            r_state   <= ST_IDLE;
                            r_settled <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_msb     = r_msb;
    assign o_isb1    = r_isb1;
    assign o_isb2    = r_isb2;
    assign o_lsb     = r_lsb;
    assign o_update  = r_update;
    assign o_settled = r_settled;
    assign o_busy    = r_busy;

endmodule

`default_nettype wire
